// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave interface.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StShift     = 2'd1,
    StWaitDesel = 2'd2
  } spi_state_e;

  localparam logic [7:0] SPI_FILL_BYTE = 8'h00;

endpackage

// File: rtl/spi_in_sync.sv
// N-stage synchroniser for one asynchronous SPI pin, with a history flop for rise/fall detect.
module spi_in_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    hist_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {Stages{ResetVal}};
      hist_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~hist_q;
  assign fall_o = ~sync_q[Stages-1] & hist_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave, oversampled in the system clock domain, with a one-entry reply register.
// Build option SPI_SLAVE_ECHO_EN: underrun fill is the last received word instead of 0x00.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  SCLK_SLAVE,
  input  logic                  SS_N_SLAVE,
  input  logic                  MOSI_SLAVE,
  output logic                  MISO_SLAVE,
  output logic                  O_MISO_OE,
  input  logic [DATA_WIDTH-1:0] I_TX_DATA,
  input  logic                  I_TX_VALID,
  output logic                  O_TX_READY,
  output logic [DATA_WIDTH-1:0] O_RX_DATA,
  output logic                  O_RX_VALID,
  output logic                  O_TX_UNDERRUN,
  output logic                  O_FRAME_ERR,
  output logic                  O_BUSY
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SetW = $clog2(SYNC_STAGES + 1);

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i (I_CLK), .rst_i (I_RESET), .d_i (SCLK_SLAVE),
    .q_o (sclk_sync_unused), .rise_o (sclk_rise), .fall_o (sclk_fall)
  );
  spi_in_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ss (
    .clk_i (I_CLK), .rst_i (I_RESET), .d_i (SS_N_SLAVE),
    .q_o (ss_sync), .rise_o (ss_rise), .fall_o (ss_fall)
  );
  spi_in_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i (I_CLK), .rst_i (I_RESET), .d_i (MOSI_SLAVE),
    .q_o (mosi_sync), .rise_o (mosi_rise_unused), .fall_o (mosi_fall_unused)
  );

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SetW-1:0]       settle_q, settle_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0] fill_word;
  logic                  settled, word_done, load;
  logic [CntW-1:0]       cnt_eff;

`ifdef SPI_SLAVE_ECHO_EN
  assign fill_word = rx_data_q;
`else
  assign fill_word = DATA_WIDTH'(SPI_FILL_BYTE);
`endif

  // The synchronisers restart from reset values, so the synced SS_N level is only
  // trustworthy once the pin value has propagated through every stage.
  assign settled   = (settle_q == SetW'(SYNC_STAGES));
  assign word_done = (cnt_q == CntW'(DATA_WIDTH));
  assign cnt_eff   = word_done ? '0 : cnt_q;

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    settle_d    = settled ? settle_q : settle_q + SetW'(1);
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      StWaitDesel: begin
        if (settled && ss_sync) state_d = StIdle;
      end
      StIdle: begin
        if (ss_fall) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (word_done) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
        end
        // Deselect takes priority over any SCLK edge seen in the same cycle.
        if (ss_rise) begin
          frame_err_d = (cnt_eff != '0);
          cnt_d       = '0;
          state_d     = StIdle;
        end else if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_sync};
          cnt_d   = cnt_eff + CntW'(1);
        end else if (sclk_fall) begin
          if (cnt_eff == '0) load = 1'b1;
          else tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = StWaitDesel;
    endcase

    if (load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d    = fill_word;
        underrun_d = 1'b1;
      end
    end

    // A write landing with a load keeps the register full: load saw the old state.
    if (I_TX_VALID && !hold_full_q) begin
      hold_d      = I_TX_DATA;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q     <= StWaitDesel;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      settle_q    <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign O_MISO_OE     = ~ss_sync;
  assign MISO_SLAVE    = tx_sr_q[DATA_WIDTH-1] & ~ss_sync;
  assign O_TX_READY    = ~hold_full_q;
  assign O_RX_DATA     = rx_data_q;
  assign O_RX_VALID    = rx_valid_q;
  assign O_TX_UNDERRUN = underrun_q;
  assign O_FRAME_ERR   = frame_err_q;
  assign O_BUSY        = (state_q == StShift);

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
Downstream peer of the SPI master top. Receives SCLK/SS_N/MOSI from the board pins and drives MISO back, all in the system clock domain by oversampling. Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first. Presents received bytes as single-cycle valid pulses and accepts reply bytes through a one-entry valid/ready holding register.

Parameters:
DATA_WIDTH, 8, bits per SPI word (shift register and data port width)
SYNC_STAGES, 2, flip-flop stages on each SPI input before edge detection (minimum 2)

Ports:
I_CLK  input  1  system clock; all logic on its rising edge
I_RESET  input  1  synchronous, active-high reset
SCLK_SLAVE  input  1  SPI clock from master, asynchronous to I_CLK
SS_N_SLAVE  input  1  SPI select, active low, asynchronous
MOSI_SLAVE  input  1  SPI data in, asynchronous
MISO_SLAVE  output  1  SPI data out
O_MISO_OE  output  1  MISO output enable for pad tristate; high while synced SS_N is low
I_TX_DATA  input  DATA_WIDTH  next reply word
I_TX_VALID  input  1  reply word offered
O_TX_READY  output  1  holding register empty
O_RX_DATA  output  DATA_WIDTH  last complete received word; held until the next word completes
O_RX_VALID  output  1  one-cycle pulse: O_RX_DATA updated
O_TX_UNDERRUN  output  1  one-cycle pulse: word load found holding register empty
O_FRAME_ERR  output  1  one-cycle pulse: SS_N deasserted mid-word
O_BUSY  output  1  high while in state SHIFT

Behaviour:
- Reset values: MISO_SLAVE=0, O_MISO_OE=0, O_TX_READY=1, O_RX_DATA=0, all pulse outputs=0, O_BUSY=0, bit counter=0. Synchroniser chains are reset to SCLK=0, SS_N=1, MOSI=0.
- Input path: SYNC_STAGES flops per input, followed by one history flop. Edge detect compares the last sync stage with the history flop. An edge is acted on SYNC_STAGES+1 I_CLK cycles after it reaches the pin.
- Operating constraint: SCLK period must be at least 8 I_CLK periods, and each SCLK high/low phase at least 3 I_CLK periods.
- FSM states: IDLE, SHIFT, WAIT_DESEL.
  - After reset: go to WAIT_DESEL. Leave only on synced SS_N=1, then enter IDLE. A frame already in progress when reset releases is therefore ignored.
  - IDLE, on SS_N falling edge: load tx shift register, drive MISO_SLAVE with its MSB, clear the bit counter, go to SHIFT.
  - SHIFT, on SCLK rising edge: shift synced MOSI into the rx shift register LSB and increment the bit counter.
    - When the counter reaches DATA_WIDTH: next cycle O_RX_DATA takes the assembled word, O_RX_VALID pulses, and the counter wraps to 0.
  - SHIFT, on SCLK falling edge:
    - Counter != 0: shift the tx register left and drive the next bit on MISO_SLAVE.
    - Counter == 0: word boundary. Reload the tx register (same rules as the frame-start load) and drive its MSB. This supports multi-word frames.
  - SHIFT, on SS_N rising edge:
    - Counter == 0: clean end of frame, go to IDLE.
    - Counter != 0: O_FRAME_ERR pulses, the partial word is discarded (no O_RX_VALID), go to IDLE.
  - Simultaneous SS_N rise and SCLK edge in the same cycle: the SS_N rise wins and the SCLK edge is ignored.
- Tx load rules:
  - Holding register full: the shift register takes its contents and O_TX_READY returns to 1 the next cycle.
  - Holding register empty: the shift register takes the fill value 0x00 (see Optional Feature) and O_TX_UNDERRUN pulses.
- Holding register handshake: a write happens on I_TX_VALID && O_TX_READY, after which O_TX_READY=0 the next cycle. A write and a load in the same cycle: the load takes the old (empty) state, the write lands, and O_TX_READY stays 0.
- O_MISO_OE follows synced SS_N=0. MISO_SLAVE is driven 0 when O_MISO_OE=0.
- Reset asserted mid-frame: all state returns to reset values in the next cycle, with no pulses and no partial O_RX_VALID.

Optional Feature:
SPI_SLAVE_ECHO_EN
- Defined: the underrun fill value is the most recent O_RX_DATA instead of 0x00. O_TX_UNDERRUN still pulses. This echoes the master's byte back to its LED display with no user logic attached.
- Undefined: the fill value is 0x00.

Decomposition:
- Shared package spi_pkg: FSM state encoding constants (IDLE=2'd0, SHIFT=2'd1, WAIT_DESEL=2'd2) and the SPI_FILL_BYTE constant (8'h00).
- One natural sub-module: spi_in_sync, an N-stage synchroniser plus rise/fall edge detector, instantiated three times (SCLK, SS_N, MOSI; the MOSI instance ignores the edge outputs).

Test Plan:
- Reset, then mode-0 frame with MOSI=0xA5 and holding register preloaded 0x3C -> O_RX_DATA=0xA5 with one O_RX_VALID pulse; MISO bit sequence 0,0,1,1,1,1,0,0; O_TX_READY back to 1 after load.
- Two-word frame, MOSI 0x12 then 0x34, only 0x55 preloaded -> two RX pulses (0x12, 0x34); MISO 0x55 then 0x00; exactly one O_TX_UNDERRUN, at the second word boundary. With SPI_SLAVE_ECHO_EN the second MISO word is 0x12.
- SS_N raised after 5 SCLK rising edges -> O_FRAME_ERR pulses once, no O_RX_VALID, O_RX_DATA keeps its previous value; the next full frame with 0x81 receives 0x81 correctly.
- I_RESET asserted at bit 4 while SS_N is still low, released, frame continues -> no RX pulse and FSM holds in WAIT_DESEL until SS_N rises; the next clean frame with 0xF0 is received.
- I_TX_VALID with 0x77 asserted in the exact cycle of the SS_N-fall load while the register is empty -> current word sends 0x00 with an underrun pulse; the next word sends 0x77.
- SCLK at the minimum 8-cycle period, 16 random bytes -> all received bytes match, all MISO bits match, O_BUSY low only between frames.
